neuron_mac_sequencer: RTL

//  Sequences one neuron's dot product through the shared pipelined 8x8 unsigned multiplier.
//  - Accepts a stream of activation/weight byte pairs and issues one pair per cycle to the multiplier.
//  - Tracks in-flight products with a tag pipe matched to the multiplier latency.
//  - Accumulates the products with a bias, then emits a scaled, saturated 8-bit neuron output over valid/ready.
//  - Sits between the layer operand buffers and the multiplier; one instance per shared multiplier.

---
 rtl/neuron_mac_sequencer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/neuron_mac_sequencer.sv
// neuron_mac_sequencer: streams operand pairs into a shared pipelined multiplier
// and accumulates one neuron's dot product into a scaled, saturated byte.
module neuron_mac_sequencer #(
    parameter int MUL_LAT   = 8,
    parameter int ACC_W     = 24,
    parameter int OUT_SHIFT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  num_inputs,
    input  logic [15:0] bias,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_act,
    input  logic [7:0]  in_wgt,
    output logic [7:0]  mul_a,
    output logic [7:0]  mul_b,
    input  logic [15:0] mul_y,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        busy,
    output logic        acc_ovf
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        OUTPUT
    } state_t;

    state_t state;
    state_t state_next;

    logic [7:0]         num;
    logic [7:0]         issued;
    logic [MUL_LAT-1:0] tag;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W:0]     sum;
    logic [ACC_W-1:0]   scaled;
    logic [7:0]         result;
    logic               accept;
    logic               last;
    logic               take_start;
    logic               acc_en;

    assign take_start = (state == IDLE) && start;
    assign in_ready   = (state == ISSUE) && (issued < num);
    assign accept     = in_ready && in_valid;
    assign last       = accept && ((issued + 8'd1) == num);

    assign mul_a = accept ? in_act : 8'd0;
    assign mul_b = accept ? in_wgt : 8'd0;

    // Oldest tag bit lines up with the product now on mul_y.
    assign acc_en = tag[MUL_LAT-1];
    assign sum    = {1'b0, acc} + {{(ACC_W + 1 - 16){1'b0}}, mul_y};

    assign scaled = acc >> OUT_SHIFT;
    assign result = (scaled > ACC_W'(255)) ? 8'hFF : scaled[7:0];

    assign out_valid = (state == OUTPUT);
    assign busy      = (state != IDLE);

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (num_inputs == 8'd0) begin
                        state_next = DRAIN;
                    end else begin
                        state_next = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (tag == '0) begin
                    state_next = OUTPUT;
                end
            end
            OUTPUT: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag <= '0;
        end else begin
            tag <= {tag[MUL_LAT-2:0], accept};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            num    <= '0;
            issued <= '0;
        end else if (take_start) begin
            num    <= num_inputs;
            issued <= '0;
        end else if (accept) begin
            issued <= issued + 8'd1;
        end
    end

    // Sum is one bit wider so a carry out means clamp and flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc     <= '0;
            acc_ovf <= 1'b0;
        end else if (take_start) begin
            acc     <= ACC_W'(bias);
            acc_ovf <= 1'b0;
        end else if (acc_en) begin
            if (sum[ACC_W]) begin
                acc     <= '1;
                acc_ovf <= 1'b1;
            end else begin
                acc <= sum[ACC_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_data <= '0;
        end else if ((state == DRAIN) && (state_next == OUTPUT)) begin
            out_data <= result;
        end
    end

endmodule
